adc_frame_sequencer: RTL

// - Upstream feeder for the two parallel MAC calc instances; replaces the convst-clocked mode counter.
// - Synchronises ADC convst into clk, captures both 12-bit channel samples per conversion and

---
 rtl/adc_frame_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer: syncs ADC convst, streams FRAME_LEN sample pairs to both MACs, then waits for both calc_done.
// Optional calc watchdog is enabled by defining SEQ_TIMEOUT_EN.
module adc_frame_sequencer #(
  parameter int FRAME_LEN      = 10,
  parameter int IDX_W          = 8,
  parameter int DATA_W         = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              convst,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic [1:0]        calc_done,
  output logic [IDX_W-1:0]  index_data,
  output logic [DATA_W-1:0] input_data0,
  output logic [DATA_W-1:0] input_data1,
  output logic              we,
  output logic              wr_stb,
  output logic [15:0]       frame_cnt,
  output logic              overrun,
  output logic              timeout
);
  typedef enum logic [1:0] {FILL, CALC, DONE} state_t;
  state_t            state_q;
  logic              s1_q, s2_q, prev_q, rise_q;
  logic [IDX_W-1:0]  cnt_q, index_q;
  logic [DATA_W-1:0] d0_q, d1_q;
  logic [1:0]        done_q;
  logic [15:0]       frame_q;
  logic              we_q, stb_q, ovr_q, tmo_q, tmo_hit, last;
  assign last = stb_q && index_q == IDX_W'(FRAME_LEN - 1);
`ifdef SEQ_TIMEOUT_EN
  logic [31:0] wdog_q;
  always_ff @(posedge clk)
    wdog_q <= (rst || state_q != CALC) ? 32'd0 : wdog_q + 32'd1;
  assign tmo_hit = state_q == CALC && wdog_q == 32'(TIMEOUT_CYCLES - 1);
`else
  assign tmo_hit = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      {s1_q, s2_q, prev_q, rise_q} <= '0;
      cnt_q   <= '0;
      index_q <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      done_q  <= '0;
      frame_q <= '0;
      we_q    <= 1'b1;
      stb_q   <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      s1_q   <= convst;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      rise_q <= s2_q & ~prev_q;
      stb_q  <= 1'b0;
      case (state_q)
        FILL:
          // the strobe for the last index must finish with we=1 before switching
          if (last) begin
            state_q <= CALC;
            we_q    <= 1'b0;
            index_q <= '0;
            ovr_q   <= ovr_q | rise_q;
          end else if (rise_q) begin
            d0_q    <= ch0_data;
            d1_q    <= ch1_data;
            index_q <= cnt_q;
            stb_q   <= 1'b1;
            cnt_q   <= cnt_q + 1'b1;
          end
        CALC: begin
          ovr_q  <= ovr_q | rise_q;
          done_q <= done_q | calc_done;
          if (tmo_hit) begin
            state_q <= FILL;
            we_q    <= 1'b1;
            tmo_q   <= 1'b1;
            done_q  <= '0;
            cnt_q   <= '0;
          end else if ((done_q | calc_done) == 2'b11) state_q <= DONE;
        end
        DONE: begin
          ovr_q   <= ovr_q | rise_q;
          frame_q <= frame_q + 16'd1;
          done_q  <= '0;
          cnt_q   <= '0;
          we_q    <= 1'b1;
          state_q <= FILL;
        end
        default: state_q <= FILL;
      endcase
    end
  end
  assign index_data  = index_q;
  assign input_data0 = d0_q;
  assign input_data1 = d1_q;
  assign we          = we_q;
  assign wr_stb      = stb_q;
  assign frame_cnt   = frame_q;
  assign overrun     = ovr_q;
  assign timeout     = tmo_q;
endmodule
